// File: rtl/mux16_scan_ctrl.sv
// Scan controller for a 16:1 mux: steps the select over the enabled channels,
// waits a settle time, and samples y into a 16-bit snapshot with valid/ready output.
module mux16_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
    input  logic [15:0] chan_en,
    input  logic        y,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] data_out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] word_q, word_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        launch;
    logic [15:0] launchMask;
    logic [4:0]  hit;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [4:0] findEnabled(input logic [15:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && i >= from) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        word_d     = word_q;
        data_d     = data_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        launch     = 1'b0;
        launchMask = mask_q;
        hit        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    launchMask = chan_en;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                word_d[sel_q] = y & mask_q[sel_q];
                hit = findEnabled(mask_q, int'(sel_q) + 1);
                if (hit[4]) begin
                    sel_d = hit[3:0];
                    if (SETTLE_CYCLES != 0) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_INIT;
                    end else begin
                        state_d = SAMPLE;
                    end
                end else begin
                    data_d  = word_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (cont) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sel_d   = 4'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty mask still spends one masked SAMPLE cycle, so its zero word
        // appears one edge after the start is accepted.
        if (launch) begin
            mask_d = launchMask;
            word_d = '0;
            hit    = findEnabled(launchMask, 0);
            sel_d  = hit[3:0];
            if (hit[4] && SETTLE_CYCLES != 0) begin
                state_d = SETTLE;
                cnt_d   = SETTLE_INIT;
            end else begin
                state_d = SAMPLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = data_q;

endmodule
